// File: rtl/ysyx_23060203_pc_gen_if.sv
// rtl/ysyx_23060203_pc_gen_if.sv - fetch request/response port between PC generator and IFU
interface ysyx_23060203_pc_gen_if #(
  parameter int XLEN = 32
) ();
  logic            pc_valid;
  logic            pc_ready;
  logic [XLEN-1:0] pc_addr;
  logic            pc_epoch;
  logic            rsp_valid;

  // PC generator side drives the request, IFU side accepts and returns responses
  modport master (output pc_valid, pc_addr, pc_epoch, input pc_ready, rsp_valid);
  modport slave  (input pc_valid, pc_addr, pc_epoch, output pc_ready, rsp_valid);
endinterface

// File: rtl/ysyx_23060203_pc_gen.sv
// rtl/ysyx_23060203_pc_gen.sv - PC generator with redirects, epoch tagging and outstanding-fetch limit
module ysyx_23060203_pc_gen #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_VEC   = 'h8000_0000,
  parameter int              FETCH_BYTES = 4,
  parameter int              IALIGN      = 32,
  parameter int              MAX_OUTST   = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  ysyx_23060203_pc_gen_if.master fetch,
  input  logic                   stall,
  input  logic                   redir_valid,
  input  logic                   redir_sel,
  input  logic [XLEN-1:0]        redir_pc,
  input  logic [XLEN-1:0]        redir_base,
  input  logic [XLEN-1:0]        redir_off,
  input  logic                   trap_valid,
  input  logic [XLEN-1:0]        trap_vec,
  output logic [2:0]             outst_cnt,
  output logic                   proto_err
);

  typedef enum logic {BOOT, RUN} state_t;

  localparam logic [XLEN-1:0] ALIGN_MASK  = (IALIGN == 16) ? ~XLEN'(1) : ~XLEN'(3);
  localparam logic [XLEN-1:0] STEP        = XLEN'(FETCH_BYTES);
  localparam logic [2:0]      OUTST_LIMIT = 3'(MAX_OUTST);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            epoch_q, epoch_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            perr_q, perr_d;

  logic            req_valid;
  logic            handshake;
  logic [XLEN-1:0] redir_target;

  assign req_valid      = (state_q == RUN) && !stall && (cnt_q < OUTST_LIMIT);
  assign handshake      = req_valid && fetch.pc_ready;
  assign redir_target   = ((redir_sel ? redir_base : redir_pc) + redir_off) & ALIGN_MASK;

  assign fetch.pc_valid = req_valid;
  assign fetch.pc_addr  = pc_q;
  assign fetch.pc_epoch = epoch_q;
  assign outst_cnt      = cnt_q;
  assign proto_err      = perr_q;

  // Next-state: boot sequencing, redirect priority over sequential advance, slot accounting
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epoch_d = epoch_q;
    cnt_d   = cnt_q;
    perr_d  = perr_q;

    case (state_q)
      BOOT:    state_d = RUN;
      RUN: begin
        state_d = RUN;
        if (trap_valid) begin
          pc_d    = trap_vec & ALIGN_MASK;
          epoch_d = ~epoch_q;
        end else if (redir_valid) begin
          pc_d    = redir_target;
          epoch_d = ~epoch_q;
        end else if (handshake) begin
          pc_d    = pc_q + STEP;
        end
      end
      default: state_d = BOOT;
    endcase

    // A response with nothing in flight is a protocol violation; the count saturates at zero
    if (fetch.rsp_valid && (cnt_q == 3'd0)) perr_d = 1'b1;
    if (handshake && !fetch.rsp_valid) begin
      cnt_d = cnt_q + 3'd1;
    end else if (!handshake && fetch.rsp_valid && (cnt_q != 3'd0)) begin
      cnt_d = cnt_q - 3'd1;
    end
  end

  // State registers with synchronous reset that also discards in-flight bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_VEC;
      epoch_q <= 1'b0;
      cnt_q   <= 3'd0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epoch_q <= epoch_d;
      cnt_q   <= cnt_d;
      perr_q  <= perr_d;
    end
  end

endmodule
